// File: rtl/vga_bounce_sprites.sv
// Bouncing-rectangle sprite generator: moves NUM_SPRITES boxes on a move tick and paints them over the active video.
// Optional feature macro: SPRITE_BORDER_EN draws a 2-pixel white ring around every sprite.
module vga_bounce_sprites #(
    parameter int unsigned H_ACTIVE    = 1024,
    parameter int unsigned V_ACTIVE    = 768,
    parameter int unsigned H_START     = 320,
    parameter int unsigned V_START     = 38,
    parameter int unsigned NUM_SPRITES = 2,
    parameter int unsigned SPR_W       = 128,
    parameter int unsigned SPR_H       = 96,
    parameter int unsigned STEP_DIV    = 650000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] h_counter,
    input  logic [11:0] v_counter,
    input  logic        video_active,
    input  logic        run,
    input  logic [3:0]  step,
    output logic [7:0]  rgb_r,
    output logic [7:0]  rgb_g,
    output logic [7:0]  rgb_b,
    output logic        bounce,
    output logic        collision
);

    localparam int unsigned CW    = 13;
    localparam int unsigned X_MAX = H_ACTIVE - SPR_W;
    localparam int unsigned Y_MAX = V_ACTIVE - SPR_H;
    localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

    function automatic logic [CW-1:0] init_x(input int unsigned i);
        return CW'((i * (SPR_W + 16)) % X_MAX);
    endfunction

    function automatic logic [CW-1:0] init_y(input int unsigned i);
        return CW'((i * (SPR_H + 8)) % Y_MAX);
    endfunction

    function automatic logic [23:0] palette(input int i);
        case (i)
            0:       return 24'ha020f0;
            1:       return 24'hff0000;
            2:       return 24'hff6100;
            3:       return 24'hffff00;
            4:       return 24'h00ff00;
            5:       return 24'h00ffff;
            6:       return 24'h0000ff;
            default: return 24'hffffff;
        endcase
    endfunction

    // One axis move: returns {reflected, new_dir, new_pos}; the position is clamped to [0, lim].
    function automatic logic [CW+1:0] axis_next(input logic [CW-1:0] pos, input logic dir,
                                                 input logic [CW-1:0] stp, input logic [CW-1:0] lim);
        logic [CW+1:0] r;
        r = {1'b0, dir, pos};
        if (stp != '0) begin
            if (!dir) begin
                if (pos + stp >= lim) r = {1'b1, 1'b1, lim};
                else                  r = {1'b0, 1'b0, pos + stp};
            end else begin
                if (pos <= stp) r = {1'b1, 1'b0, CW'(0)};
                else            r = {1'b0, 1'b1, pos - stp};
            end
        end
        return r;
    endfunction

    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             tick_c;
    logic [NUM_SPRITES-1:0][CW-1:0]   spr_x_q, spr_x_d, spr_y_q, spr_y_d;
    logic [NUM_SPRITES-1:0]           h_dir_q, h_dir_d, v_dir_q, v_dir_d;
    logic [NUM_SPRITES-1:0]           refl_x, refl_y;
    logic                             bounce_q, bounce_d;
    logic                             collision_q, collision_d;
    logic [23:0]                      rgb_q, rgb_d;
    logic [CW-1:0]                    step_ext;
    logic signed [CW-1:0]             px, py;
    logic [NUM_SPRITES-1:0]           hit;
    logic [3:0]                       n_hit;
    logic [23:0]                      colour;
`ifdef SPRITE_BORDER_EN
    logic [CW-1:0]                    rel_x, rel_y;
`endif

    assign step_ext = CW'(step);
    assign px       = $signed(CW'(h_counter) - CW'(H_START));
    assign py       = $signed(CW'(v_counter) - CW'(V_START));

    // Move-tick divider; frozen while run is low
    always_comb begin
        cnt_d  = cnt_q;
        tick_c = 1'b0;
        if (run) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                tick_c = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Per-sprite, per-axis motion with edge reflection
    always_comb begin
        spr_x_d = spr_x_q;
        spr_y_d = spr_y_q;
        h_dir_d = h_dir_q;
        v_dir_d = v_dir_q;
        refl_x  = '0;
        refl_y  = '0;
        if (tick_c) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                {refl_x[i], h_dir_d[i], spr_x_d[i]} =
                    axis_next(spr_x_q[i], h_dir_q[i], step_ext, CW'(X_MAX));
                {refl_y[i], v_dir_d[i], spr_y_d[i]} =
                    axis_next(spr_y_q[i], v_dir_q[i], step_ext, CW'(Y_MAX));
            end
        end
        bounce_d = |{refl_x, refl_y};
    end

    // Pixel hit test; scanning from the top index down lets the lowest hit index win
    always_comb begin
        hit    = '0;
        n_hit  = '0;
        colour = 24'h000000;
`ifdef SPRITE_BORDER_EN
        rel_x  = '0;
        rel_y  = '0;
`endif
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            hit[i] = (px >= $signed(spr_x_q[i])) && (px < $signed(spr_x_q[i] + CW'(SPR_W))) &&
                     (py >= $signed(spr_y_q[i])) && (py < $signed(spr_y_q[i] + CW'(SPR_H)));
            n_hit  = n_hit + 4'(hit[i]);
`ifdef SPRITE_BORDER_EN
            rel_x = $unsigned(px) - spr_x_q[i];
            rel_y = $unsigned(py) - spr_y_q[i];
            if (hit[i]) begin
                if ((rel_x < CW'(2)) || (rel_x >= CW'(SPR_W - 2)) ||
                    (rel_y < CW'(2)) || (rel_y >= CW'(SPR_H - 2)))
                    colour = 24'hffffff;
                else
                    colour = palette(i);
            end
`else
            if (hit[i]) colour = palette(i);
`endif
        end
        rgb_d       = video_active ? colour : 24'h000000;
        collision_d = video_active && (n_hit >= 4'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            bounce_q    <= 1'b0;
            collision_q <= 1'b0;
            rgb_q       <= 24'h000000;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                spr_x_q[i] <= init_x(i);
                spr_y_q[i] <= init_y(i);
                h_dir_q[i] <= 1'(i % 2);
                v_dir_q[i] <= 1'b0;
            end
        end else begin
            cnt_q       <= cnt_d;
            bounce_q    <= bounce_d;
            collision_q <= collision_d;
            rgb_q       <= rgb_d;
            spr_x_q     <= spr_x_d;
            spr_y_q     <= spr_y_d;
            h_dir_q     <= h_dir_d;
            v_dir_q     <= v_dir_d;
        end
    end

    assign rgb_r     = rgb_q[23:16];
    assign rgb_g     = rgb_q[15:8];
    assign rgb_b     = rgb_q[7:0];
    assign bounce    = bounce_q;
    assign collision = collision_q;

endmodule
